mips_fetch_unit: RTL and testbench
==================================

// Module: mips_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. Replaces the bare PC/adder/mux/IF_ID path.
//  Adds four things to that path:
//   - IF-stage predecode of j/jal, taken with zero bubbles.
//   - A 2-bit branch history table (BHT) that predicts beq/bne.
//   - ID-stage redirect for mispredicts and jr.
//   - Branch and mispredict performance counters.
//  The program memory reads combinationally; the IF/ID register sits inside this block.
// PARAMETERS
//  PC_INCREMENT  4   sequential PC step (bytes)
//  RESET_PC      0   PC value loaded on reset
//  BHT_ENTRIES   16  number of 2-bit counters; power of 2, >=2; index = pc[log2(BHT_ENTRIES)+1:2]
// PORTS
//  clk                    in  1   clock, rising edge
//  reset                  in  1   synchronous, active-high
//  stall                  in  1   hazard unit: hold PC, IF/ID and counters
//  imem_addr              out 32  program memory address (= PC)
//  imem_instr             in  32  instruction at imem_addr, same cycle
//  if_id_instr            out 32  IF/ID instruction (0 = nop when flushed)
//  if_id_pc_plus_4        out 32  IF/ID PC+PC_INCREMENT
//  if_id_predicted_taken  out 1   IF/ID: fetch redirected by BHT prediction
//  if_id_valid            out 1   IF/ID holds a real instruction
//  id_branch_valid        in  1   ID resolved a beq/bne this cycle
//  id_branch_taken        in  1   actual outcome
//  id_branch_pc           in  32  PC of the resolved branch (BHT index)
//  id_branch_target       in  32  taken target computed in ID
//  id_predicted_taken     in  1   if_id_predicted_taken carried with that branch
//  id_jr                  in  1   ID holds jr
//  id_jr_target           in  32  forwarded rs value
//  branch_count           out 32  resolved branches since reset
//  mispredict_count       out 32  mispredicted branches since reset
// BEHAVIOUR
//  Reset (sync, dominates everything):
//   - PC = RESET_PC; IF/ID instr, pc_plus_4, predicted_taken and valid = 0.
//   - Both counters = 0; all BHT entries = 2'b01 (weakly not-taken).
//  Latency: imem_instr is captured into IF/ID on the next rising edge (1 cycle).
//  Next-PC priority, highest first:
//   1 reset.
//   2 stall=1: PC, IF/ID, BHT and counters all hold. Any id_* request this cycle is ignored; ID re-presents it.
//   3 ID redirect. mispredict = id_branch_valid & (id_branch_taken != id_predicted_taken); redirect = mispredict | id_jr.
//     - PC = id_jr ? id_jr_target : (id_branch_taken ? id_branch_target : id_branch_pc+PC_INCREMENT).
//     - IF/ID is flushed: instr=0, valid=0, predicted_taken=0. Penalty is 1 bubble.
//   4 IF predecode on imem_instr[31:26]. imem_instr is captured normally, valid=1.
//     - j (6'h02) / jal (6'h03): PC = {pc_plus_4[31:28], instr[25:0], 2'b00}. predicted_taken=0.
//     - beq (6'h04) / bne (6'h05) with BHT[pc] >= 2'b10: PC = pc_plus_4 + (sext(instr[15:0])<<2); predicted_taken=1.
//   5 otherwise PC = PC + PC_INCREMENT. pc_plus_4 is 32-bit and wraps modulo 2^32.
//  BHT update, on id_branch_valid & ~stall:
//   - Entry at id_branch_pc: +1 if taken, -1 if not. Saturates at 2'b11 and 2'b00.
//   - Updated even on mispredict.
//  Same-cycle BHT read and update of one index: the read returns the old value (no bypass).
//  Counters, on id_branch_valid & ~stall: branch_count +1; mispredict_count +1 if mispredict. Both wrap modulo 2^32.
//  id_jr with id_branch_valid in the same cycle: jr target wins. The BHT and counters still update.
//  Reset asserted mid-redirect or mid-stall: the reset values above apply on that edge.
// STRUCTURE
//  Shared package:
//   - Opcode constants OP_J=6'h02, OP_JAL=6'h03, OP_BEQ=6'h04, OP_BNE=6'h05.
//   - BHT states SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
//  Sub-module branch_history_table (params ENTRIES):
//   - Ports: clk, reset, rd_idx, rd_taken, wr_en, wr_idx, wr_taken.
//   - Combinational read, synchronous saturating update.
//  Top holds: PC register, predecode, next-PC priority mux, IF/ID register, counters.
// TESTING
//  1 reset=1 for 2 cycles, then 0 -> imem_addr=0, if_id_valid=0, if_id_instr=0, both counters 0.
//  2 imem_instr=32'h20080001 at PC 0 -> next cycle: if_id_pc_plus_4=4, if_id_valid=1, imem_addr=4.
//  3 PC 0x8, imem_instr=32'h08000010 (j) -> next imem_addr=0x40, if_id_instr=32'h08000010, no bubble.
//  4 beq at PC 0x10, imm=3, BHT=WNT, ID reports taken to target 0x20:
//    - Next cycle: imem_addr=0x20, if_id_valid=0, mispredict_count=1, branch_count=1.
//    - BHT index 4 = WT, so the refetch at PC 0x10 predicts taken: next PC=0x20, if_id_predicted_taken=1.
//  5 stall=1 for 2 cycles with id_branch_valid=1 -> imem_addr and IF/ID unchanged, counters unchanged, BHT unchanged.
//  6 id_jr=1, target 0x100, while IF fetches a j -> imem_addr=0x100, IF/ID flushed.
//    Then 4 taken updates on one index -> BHT reads ST (2'b11), no wrap.

Source files
------------

// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the MIPS fetch unit: opcodes that the IF stage predecodes
// and the 2-bit branch history counter encoding with its saturating update.
package mips_fetch_unit_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    function automatic bht_state_t bht_step(input bht_state_t s, input logic taken);
        bht_state_t r;
        r = s;
        if (taken && s != ST) begin
            r = bht_state_t'(s + 2'd1);
        end else if (!taken && s != SNT) begin
            r = bht_state_t'(s - 2'd1);
        end
        return r;
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/mips_fetch_unit_bht.sv
// Table of 2-bit saturating branch predictors. The read is combinational and sees
// the pre-update value when the same index is written in that cycle.
module branch_history_table
    import mips_fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_state_t r_bht [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= WNT;
            end
        end else if (wr_en) begin
            r_bht[wr_idx] <= bht_step(r_bht[wr_idx], wr_taken);
        end
    end

    assign rd_taken = (r_bht[rd_idx] >= WT);

endmodule

// File: rtl/mips_fetch_unit.sv
// IF stage: PC register, j/jal and BHT-predicted branch predecode, ID redirect
// for mispredicts and jr, the IF/ID pipeline register and branch statistics.
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_INCREMENT = 32'd4,
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter int          BHT_ENTRIES  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus_4,
    output logic        if_id_predicted_taken,
    output logic        if_id_valid,
    input  logic        id_branch_valid,
    input  logic        id_branch_taken,
    input  logic [31:0] id_branch_pc,
    input  logic [31:0] id_branch_target,
    input  logic        id_predicted_taken,
    input  logic        id_jr,
    input  logic [31:0] id_jr_target,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0] r_pc, r_instr, r_pc_plus_4, r_branch_cnt, r_mispred_cnt;
    logic        r_pred, r_valid;

    logic [31:0] w_pc_plus_4, w_jump_target, w_branch_target, w_next_pc;
    logic [5:0]  w_opcode;
    logic        w_bht_taken, w_mispredict, w_redirect, w_update, w_pred_next;

    assign w_pc_plus_4     = r_pc + PC_INCREMENT;
    assign w_opcode        = imem_instr[31:26];
    assign w_jump_target   = {w_pc_plus_4[31:28], imem_instr[25:0], 2'b00};
    assign w_branch_target = w_pc_plus_4 + {{14{imem_instr[15]}}, imem_instr[15:0], 2'b00};
    assign w_mispredict    = id_branch_valid & (id_branch_taken != id_predicted_taken);
    assign w_redirect      = w_mispredict | id_jr;
    assign w_update        = id_branch_valid & ~stall;

    branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (r_pc[IDX_W+1:2]),
        .rd_taken (w_bht_taken),
        .wr_en    (w_update),
        .wr_idx   (id_branch_pc[IDX_W+1:2]),
        .wr_taken (id_branch_taken)
    );

    // ID redirect outranks anything predecoded from the instruction currently in IF.
    always_comb begin
        w_next_pc   = w_pc_plus_4;
        w_pred_next = 1'b0;
        if (w_redirect) begin
            if (id_jr) begin
                w_next_pc = id_jr_target;
            end else if (id_branch_taken) begin
                w_next_pc = id_branch_target;
            end else begin
                w_next_pc = id_branch_pc + PC_INCREMENT;
            end
        end else if (is_jump(w_opcode)) begin
            w_next_pc = w_jump_target;
        end else if (is_cond_branch(w_opcode) && w_bht_taken) begin
            w_next_pc   = w_branch_target;
            w_pred_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_pc_plus_4   <= '0;
            r_pred        <= 1'b0;
            r_valid       <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (!stall) begin
            r_pc        <= w_next_pc;
            r_pc_plus_4 <= w_pc_plus_4;
            r_instr     <= w_redirect ? 32'd0 : imem_instr;
            r_valid     <= ~w_redirect;
            r_pred      <= w_pred_next;
            if (id_branch_valid) begin
                r_branch_cnt  <= r_branch_cnt + 32'd1;
                r_mispred_cnt <= r_mispred_cnt + {31'd0, w_mispredict};
            end
        end
    end

    assign imem_addr             = r_pc;
    assign if_id_instr           = r_instr;
    assign if_id_pc_plus_4       = r_pc_plus_4;
    assign if_id_predicted_taken = r_pred;
    assign if_id_valid           = r_valid;
    assign branch_count          = r_branch_cnt;
    assign mispredict_count      = r_mispred_cnt;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: directed scenarios followed by random
// traffic, each cycle predicted by a behavioural model and checked by a monitor.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_id_instr, if_id_pc_plus_4;
    logic        if_id_predicted_taken, if_id_valid;
    logic        id_branch_valid, id_branch_taken, id_predicted_taken, id_jr;
    logic [31:0] id_branch_pc, id_branch_target, id_jr_target;
    logic [31:0] branch_count, mispredict_count;

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk                   (clk),
        .reset                 (reset),
        .stall                 (stall),
        .imem_addr             (imem_addr),
        .imem_instr            (imem_instr),
        .if_id_instr           (if_id_instr),
        .if_id_pc_plus_4       (if_id_pc_plus_4),
        .if_id_predicted_taken (if_id_predicted_taken),
        .if_id_valid           (if_id_valid),
        .id_branch_valid       (id_branch_valid),
        .id_branch_taken       (id_branch_taken),
        .id_branch_pc          (id_branch_pc),
        .id_branch_target      (id_branch_target),
        .id_predicted_taken    (id_predicted_taken),
        .id_jr                 (id_jr),
        .id_jr_target          (id_jr_target),
        .branch_count          (branch_count),
        .mispredict_count      (mispredict_count)
    );

    typedef struct {
        logic [31:0] pc, instr, pp4, bc, mc;
        logic        pt, valid;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pp4, m_bc, m_mc;
    logic        m_pt, m_valid;
    int          m_bht [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int                 ri, wi;
        bit                 pred, mis;
        logic [31:0]        pp4, npc;
        logic signed [31:0] off;
        exp_t               e;
        if (reset) begin
            m_pc = 0; m_instr = 0; m_pp4 = 0; m_pt = 0; m_valid = 0; m_bc = 0; m_mc = 0;
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
        end else if (!stall) begin
            ri   = int'((m_pc / 4) % 16);
            pred = (m_bht[ri] >= 2);
            mis  = id_branch_valid && (id_branch_taken != id_predicted_taken);
            pp4  = m_pc + 32'd4;
            if (id_branch_valid) begin
                wi = int'((id_branch_pc / 4) % 16);
                m_bc = m_bc + 1;
                if (mis) m_mc = m_mc + 1;
                if (id_branch_taken) m_bht[wi] = (m_bht[wi] == 3) ? 3 : m_bht[wi] + 1;
                else                 m_bht[wi] = (m_bht[wi] == 0) ? 0 : m_bht[wi] - 1;
            end
            if (mis || id_jr) begin
                npc = id_jr ? id_jr_target : (id_branch_taken ? id_branch_target : id_branch_pc + 32'd4);
                m_instr = 0; m_valid = 0; m_pt = 0;
            end else begin
                m_instr = imem_instr; m_valid = 1; m_pt = 0; npc = pp4;
                if (imem_instr[31:26] == 6'h02 || imem_instr[31:26] == 6'h03) begin
                    npc = {pp4[31:28], imem_instr[25:0], 2'b00};
                end else if ((imem_instr[31:26] == 6'h04 || imem_instr[31:26] == 6'h05) && pred) begin
                    off = $signed(imem_instr[15:0]);
                    npc = pp4 + off * 4;
                    m_pt = 1;
                end
            end
            m_pp4 = pp4;
            m_pc  = npc;
        end
        e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.bc = m_bc; e.mc = m_mc;
        e.pt = m_pt; e.valid = m_valid;
        sb.push_back(e);
    endtask

    // One clock: predict the post-edge state, then return at the following negedge.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; id_branch_valid = 0; id_branch_taken = 0; id_predicted_taken = 0;
        id_branch_pc = 0; id_branch_target = 0; id_jr = 0; id_jr_target = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("imem_addr", imem_addr, mon_e.pc);
            chk("if_id_instr", if_id_instr, mon_e.instr);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, mon_e.valid});
            chk("if_id_pred", {31'd0, if_id_predicted_taken}, {31'd0, mon_e.pt});
            chk("branch_count", branch_count, mon_e.bc);
            chk("mispredict_count", mispredict_count, mon_e.mc);
            if (mon_e.valid) chk("if_id_pc_plus_4", if_id_pc_plus_4, mon_e.pp4);
        end
    end

    initial begin
        idle();
        reset = 1; imem_instr = 0;
        @(negedge clk);
        tick(); tick();
        reset = 0;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_bc", branch_count, 32'd0);
        chk("rst_mc", mispredict_count, 32'd0);

        imem_instr = 32'h20080001; tick();
        chk("seq_pp4", if_id_pc_plus_4, 32'h4);
        chk("seq_valid", {31'd0, if_id_valid}, 32'd1);
        chk("seq_addr", imem_addr, 32'h4);
        imem_instr = 32'h0; tick();
        imem_instr = 32'h08000010; tick();
        chk("j_addr", imem_addr, 32'h40);
        chk("j_instr", if_id_instr, 32'h08000010);
        chk("j_valid", {31'd0, if_id_valid}, 32'd1);

        // Mispredicted beq at 0x10, then refetch predicted taken.
        reset = 1; tick(); reset = 0;
        imem_instr = 32'h0;
        repeat (4) tick();
        imem_instr = 32'h10000003; tick();
        chk("beq_nt_addr", imem_addr, 32'h14);
        imem_instr = 32'h0;
        id_branch_valid = 1; id_branch_taken = 1; id_branch_pc = 32'h10;
        id_branch_target = 32'h20; id_predicted_taken = 0;
        tick(); idle();
        chk("mis_addr", imem_addr, 32'h20);
        chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
        chk("mis_mc", mispredict_count, 32'd1);
        chk("mis_bc", branch_count, 32'd1);
        id_jr = 1; id_jr_target = 32'h10; tick(); idle();
        imem_instr = 32'h10000003; tick();
        chk("pred_addr", imem_addr, 32'h20);
        chk("pred_taken", {31'd0, if_id_predicted_taken}, 32'd1);

        // Stall with a pending branch: everything holds.
        imem_instr = 32'h0; stall = 1;
        id_branch_valid = 1; id_branch_taken = 1; id_branch_pc = 32'h10; id_predicted_taken = 0;
        tick(); tick(); idle();
        chk("stall_addr", imem_addr, 32'h20);
        chk("stall_pred", {31'd0, if_id_predicted_taken}, 32'd1);
        chk("stall_bc", branch_count, 32'd1);
        chk("stall_mc", mispredict_count, 32'd1);

        // jr beats a j being fetched.
        imem_instr = 32'h08000010; id_jr = 1; id_jr_target = 32'h100; tick(); idle();
        chk("jr_addr", imem_addr, 32'h100);
        chk("jr_valid", {31'd0, if_id_valid}, 32'd0);
        chk("jr_instr", if_id_instr, 32'h0);

        // Saturation: 4 taken then 1 not-taken on index 12 must still predict taken.
        imem_instr = 32'h0;
        id_branch_valid = 1; id_branch_pc = 32'h30; id_branch_taken = 1; id_predicted_taken = 1;
        repeat (4) tick();
        id_branch_taken = 0; id_predicted_taken = 0; tick(); idle();
        id_jr = 1; id_jr_target = 32'h30; tick(); idle();
        imem_instr = 32'h14000002; tick();
        chk("sat_pred", {31'd0, if_id_predicted_taken}, 32'd1);
        chk("sat_addr", imem_addr, 32'h3C);
        chk("sat_bc", branch_count, 32'd6);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int k;
            k = int'($urandom_range(0, 5));
            imem_instr = $urandom;
            case (k)
                0: imem_instr[31:26] = 6'h02;
                1: imem_instr[31:26] = 6'h03;
                2: imem_instr[31:26] = 6'h04;
                3: imem_instr[31:26] = 6'h05;
                4: imem_instr[31:26] = 6'h00;
                default: imem_instr[31:26] = 6'h23;
            endcase
            reset              = ($urandom_range(0, 99) == 0);
            stall              = ($urandom_range(0, 4) == 0);
            id_branch_valid    = ($urandom_range(0, 9) < 3);
            id_branch_taken    = $urandom_range(0, 1) == 1;
            id_predicted_taken = $urandom_range(0, 1) == 1;
            id_branch_pc       = $urandom & 32'hFFFF_FFFC;
            id_branch_target   = $urandom & 32'hFFFF_FFFC;
            id_jr              = ($urandom_range(0, 9) == 0);
            id_jr_target       = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        reset = 0; idle(); imem_instr = 0;
        tick();
        @(posedge clk); #2;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
